// File: rtl/wci_axi_target_adapter_if.sv
// AXI4-Lite channel bundle between the WCI::AXI initiator (master) and the
// WCI0 target adapter (slave).
interface wci_axi_target_adapter_if #(
    parameter int ADDR_W = 32
);
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              WVALID;
    logic              WREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              RVALID;
    logic              RREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/wci_axi_target_adapter.sv
// AXI4-Lite slave for the WCI0 link: serializes writes/reads onto a
// single-outstanding worker register port, with a watchdog forcing completion.
module wci_axi_target_adapter #(
    parameter int          ADDR_W   = 32,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] TO_RDATA = 32'hC0DE_7170
) (
    input  logic                 wciS0_ACLK,
    input  logic                 wciS0_ARESETn,
    wci_axi_target_adapter_if.slave wciS0,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic                 req_write,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [31:0]          req_wdata,
    output logic [3:0]           req_be,
    input  logic                 rsp_valid,
    input  logic [31:0]          rsp_data,
    input  logic                 rsp_err,
    output logic                 req_abort,
    output logic [7:0]           timeout_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              aw_h_q, aw_h_d, w_h_q, w_h_d, ar_h_q, ar_h_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              last_wr_q, last_wr_d, cur_wr_q, cur_wr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [3:0]        req_be_q, req_be_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              abort_q, abort_d;
    logic [7:0]        to_cnt_q, to_cnt_d;
    logic              to_hit, wr_ok, rd_ok;

    always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
        if (!wciS0_ARESETn) begin
            state_q     <= ST_IDLE;
            aw_h_q      <= 1'b0;
            w_h_q       <= 1'b0;
            ar_h_q      <= 1'b0;
            aw_addr_q   <= '0;
            ar_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            last_wr_q   <= 1'b0;
            cur_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            cnt_q       <= '0;
            resp_q      <= '0;
            rdata_q     <= '0;
            abort_q     <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            aw_h_q      <= aw_h_d;
            w_h_q       <= w_h_d;
            ar_h_q      <= ar_h_d;
            aw_addr_q   <= aw_addr_d;
            ar_addr_q   <= ar_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            last_wr_q   <= last_wr_d;
            cur_wr_q    <= cur_wr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            abort_q     <= abort_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        aw_h_d      = aw_h_q;
        w_h_d       = w_h_q;
        ar_h_d      = ar_h_q;
        aw_addr_d   = aw_addr_q;
        ar_addr_d   = ar_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        last_wr_d   = last_wr_q;
        cur_wr_d    = cur_wr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        rdata_d     = rdata_q;
        abort_d     = 1'b0;
        to_cnt_d    = to_cnt_q;
        to_hit      = 1'b0;
        wr_ok       = aw_h_q && w_h_q;
        rd_ok       = ar_h_q;

        // Capture and launch-clear never collide: a holding register only
        // accepts a beat while empty and is only launched while full.
        if (wciS0.AWVALID && !aw_h_q) begin
            aw_h_d    = 1'b1;
            aw_addr_d = wciS0.AWADDR;
        end
        if (wciS0.WVALID && !w_h_q) begin
            w_h_d    = 1'b1;
            w_data_d = wciS0.WDATA;
            w_strb_d = wciS0.WSTRB;
        end
        if (wciS0.ARVALID && !ar_h_q) begin
            ar_h_d    = 1'b1;
            ar_addr_d = wciS0.ARADDR;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    cur_wr_d    = 1'b1;
                    last_wr_d   = 1'b1;
                    req_addr_d  = aw_addr_q;
                    req_wdata_d = w_data_q;
                    req_be_d    = w_strb_q;
                    aw_h_d      = 1'b0;
                    w_h_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_REQ;
                end else if (rd_ok) begin
                    cur_wr_d    = 1'b0;
                    last_wr_d   = 1'b0;
                    req_addr_d  = ar_addr_q;
                    req_wdata_d = '0;
                    req_be_d    = 4'hF;
                    ar_h_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == TO_LAST) begin
                    to_hit = 1'b1;
                end else if (req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (rsp_valid) begin
                    resp_d  = rsp_err ? 2'b10 : 2'b00;
                    if (!cur_wr_q) rdata_d = rsp_data;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    to_hit = 1'b1;
                end
            end
            ST_RESP: begin
                if (cur_wr_q ? wciS0.BREADY : wciS0.RREADY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_hit) begin
            abort_d  = 1'b1;
            resp_d   = 2'b10;
            if (!cur_wr_q) rdata_d = TO_RDATA;
            to_cnt_d = (to_cnt_q == 8'hFF) ? 8'hFF : to_cnt_q + 8'd1;
            state_d  = ST_RESP;
        end
    end

    assign wciS0.AWREADY = !aw_h_q;
    assign wciS0.WREADY  = !w_h_q;
    assign wciS0.ARREADY = !ar_h_q;
    assign wciS0.BVALID  = (state_q == ST_RESP) && cur_wr_q;
    assign wciS0.RVALID  = (state_q == ST_RESP) && !cur_wr_q;
    assign wciS0.BRESP   = resp_q;
    assign wciS0.RRESP   = resp_q;
    assign wciS0.RDATA   = rdata_q;

    assign req_valid     = (state_q == ST_REQ);
    assign req_write     = cur_wr_q;
    assign req_addr      = req_addr_q;
    assign req_wdata     = req_wdata_q;
    assign req_be        = req_be_q;
    assign req_abort     = abort_q;
    assign timeout_count = to_cnt_q;

endmodule
